// File: rtl/spi_rx_deser_pkg.sv
// Shared encodings for the SPI receive deserializer: IO mode, word size, beat helpers.
// Imported by the deserializer top and its holding buffer.
package spi_rx_deser_pkg;

   localparam logic [1:0] SPI_STD_SPI  = 2'd0;
   localparam logic [1:0] SPI_DUAL_SPI = 2'd1;
   localparam logic [1:0] SPI_QUAD_SPI = 2'd2;

   localparam logic [1:0] SPI_SIZE_8  = 2'd0;
   localparam logic [1:0] SPI_SIZE_16 = 2'd1;
   localparam logic [1:0] SPI_SIZE_24 = 2'd2;
   localparam logic [1:0] SPI_SIZE_32 = 2'd3;

   // Mode 3 is reserved and behaves as std.
   function automatic logic [2:0] beat_width(input logic [1:0] mode);
      case (mode)
         SPI_DUAL_SPI: return 3'd2;
         SPI_QUAD_SPI: return 3'd4;
         default:      return 3'd1;
      endcase
   endfunction

   function automatic logic [5:0] word_bits(input logic [1:0] size);
      case (size)
         SPI_SIZE_8:  return 6'd8;
         SPI_SIZE_16: return 6'd16;
         SPI_SIZE_24: return 6'd24;
         SPI_SIZE_32: return 6'd32;
         default:     return 6'd32;
      endcase
   endfunction

endpackage

// File: rtl/spi_rx_deser_if.sv
// Valid/ready word channel from the RX deserializer to the RX FIFO / register side.
// master drives the word, slave drives ready.
interface spi_rx_deser_if;
   logic        rx_valid_o;
   logic        rx_ready_i;
   logic [31:0] rx_data_o;

   modport master (output rx_valid_o, output rx_data_o, input rx_ready_i);
   modport slave  (input rx_valid_o, input rx_data_o, output rx_ready_i);
endinterface

// File: rtl/spi_rx_deser_buf.sv
// spi_rx_buf: valid/ready word holding buffer, depth 2 with SPI_RX_BUF2_EN else depth 1.
// Pop frees a slot before a same-cycle push; a push into a full buffer is dropped (drop_o).
module spi_rx_buf (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        clr_i,
   input  logic        push_i,
   input  logic [31:0] push_dat_i,
   input  logic        rdy_i,
   output logic        vld_o,
   output logic [31:0] dat_o,
   output logic        drop_o
);

`ifdef SPI_RX_BUF2_EN
   logic [1:0]  r_cnt;
   logic [31:0] r_dat0;
   logic [31:0] r_dat1;
   logic        w_pop;
   logic        w_wr;
   logic [1:0]  w_cnt_aft;

   assign w_pop     = (r_cnt != 2'd0) & rdy_i;
   assign w_cnt_aft = r_cnt - {1'b0, w_pop};
   assign drop_o    = push_i & (w_cnt_aft == 2'd2);
   assign w_wr      = push_i & ~drop_o;

   // r_dat0 is always the head; a pop shifts the tail forward, a write lands after it.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_cnt  <= 2'd0;
         r_dat0 <= 32'd0;
         r_dat1 <= 32'd0;
      end else if (clr_i) begin
         r_cnt  <= 2'd0;
         r_dat0 <= 32'd0;
         r_dat1 <= 32'd0;
      end else begin
         if (w_pop)
            r_dat0 <= r_dat1;
         if (w_wr && (w_cnt_aft == 2'd0))
            r_dat0 <= push_dat_i;
         if (w_wr && (w_cnt_aft == 2'd1))
            r_dat1 <= push_dat_i;
         r_cnt <= w_cnt_aft + {1'b0, w_wr};
      end
   end

   assign vld_o = (r_cnt != 2'd0);
   assign dat_o = r_dat0;
`else
   logic        r_vld;
   logic [31:0] r_dat;
   logic        w_pop;

   assign w_pop  = r_vld & rdy_i;
   assign drop_o = push_i & r_vld & ~w_pop;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_vld <= 1'b0;
         r_dat <= 32'd0;
      end else if (clr_i) begin
         r_vld <= 1'b0;
         r_dat <= 32'd0;
      end else if (push_i && !drop_o) begin
         r_vld <= 1'b1;
         r_dat <= push_dat_i;
      end else if (w_pop) begin
         r_vld <= 1'b0;
      end
   end

   assign vld_o = r_vld;
   assign dat_o = r_dat;
`endif

endmodule

// File: rtl/spi_rx_deser.sv
// SPI RX deserializer: packs std/dual/quad beats into 8..32-bit words, word valid 1 cycle after last beat.
// Backpressure via rx_ready_i into a 1-entry (or 2-entry with SPI_RX_BUF2_EN) buffer; drops set sticky ovf_o.
module spi_rx_deser
   import spi_rx_deser_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  clr_i,
   input  logic                  en_i,
   input  logic                  smp_i,
   input  logic [1:0]            mode_i,
   input  logic [1:0]            size_i,
   input  logic                  lsb_i,
   input  logic [3:0]            spi_io_in_i,
   spi_rx_deser_if.master        rx_if,
   output logic                  ovf_o,
   output logic [5:0]            bit_cnt_o
);

   logic [31:0] r_shreg;
   logic [5:0]  r_bit_cnt;
   logic        r_ovf;

   logic [2:0]  w_beat_w;
   logic [3:0]  w_beat;
   logic [5:0]  w_word_bits;
   logic [5:0]  w_cnt_nxt;
   logic        w_cap;
   logic        w_done;
   logic        w_push;
   logic        w_drop;
   logic [31:0] w_sh_nxt;
   logic [31:0] w_mask;
   logic [31:0] w_word;

   always_comb begin
      case (mode_i)
         SPI_DUAL_SPI: w_beat = {2'b00, spi_io_in_i[1:0]};
         SPI_QUAD_SPI: w_beat = spi_io_in_i;
         default:      w_beat = {3'b000, spi_io_in_i[1]};
      endcase
   end

   assign w_beat_w    = beat_width(mode_i);
   assign w_word_bits = word_bits(size_i);
   assign w_cap       = en_i & smp_i;
   assign w_cnt_nxt   = r_bit_cnt + {3'b000, w_beat_w};
   // >= rather than == keeps the counter bounded if the config is changed mid-word.
   assign w_done      = (w_cnt_nxt >= w_word_bits);
   assign w_sh_nxt    = lsb_i ? (r_shreg | ({28'd0, w_beat} << r_bit_cnt))
                              : ((r_shreg << w_beat_w) | {28'd0, w_beat});
   assign w_mask      = ~(32'hFFFF_FFFF << w_word_bits);
   assign w_word      = w_sh_nxt & w_mask;
   assign w_push      = w_cap & w_done;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_shreg   <= 32'd0;
         r_bit_cnt <= 6'd0;
         r_ovf     <= 1'b0;
      end else if (clr_i) begin
         r_shreg   <= 32'd0;
         r_bit_cnt <= 6'd0;
         r_ovf     <= 1'b0;
      end else begin
         if (!en_i) begin
            r_shreg   <= 32'd0;
            r_bit_cnt <= 6'd0;
         end else if (w_cap) begin
            r_shreg   <= w_done ? 32'd0 : w_sh_nxt;
            r_bit_cnt <= w_done ? 6'd0  : w_cnt_nxt;
         end
         if (w_drop)
            r_ovf <= 1'b1;
      end
   end

   spi_rx_buf u_buf (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .clr_i      (clr_i),
      .push_i     (w_push),
      .push_dat_i (w_word),
      .rdy_i      (rx_if.rx_ready_i),
      .vld_o      (rx_if.rx_valid_o),
      .dat_o      (rx_if.rx_data_o),
      .drop_o     (w_drop)
   );

   assign ovf_o     = r_ovf;
   assign bit_cnt_o = r_bit_cnt;

endmodule

// File: tb/tb_spi_rx_deser.sv
// Bench for spi_rx_deser: directed scenarios plus randomized traffic against a beat-list reference model.
// Buffer depth follows SPI_RX_BUF2_EN.
module tb_spi_rx_deser;

`ifdef SPI_RX_BUF2_EN
   localparam int DEPTH = 2;
`else
   localparam int DEPTH = 1;
`endif

   logic       clk_i = 1'b0;
   logic       rst_n_i, clr_i, en_i, smp_i, lsb_i;
   logic [1:0] mode_i, size_i;
   logic [3:0] spi_io_in_i;
   logic       ovf_o;
   logic [5:0] bit_cnt_o;

   spi_rx_deser_if rx_if ();

   spi_rx_deser dut (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .clr_i       (clr_i),
      .en_i        (en_i),
      .smp_i       (smp_i),
      .mode_i      (mode_i),
      .size_i      (size_i),
      .lsb_i       (lsb_i),
      .spi_io_in_i (spi_io_in_i),
      .rx_if       (rx_if),
      .ovf_o       (ovf_o),
      .bit_cnt_o   (bit_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   int n_chk = 0;
   int n_bad = 0;

   // Reference model: words waiting for the consumer, beats of the current word, overflow flag.
   logic [31:0] exp_q[$];
   int          beat_q[$];
   int          m_cnt = 0;
   bit          m_ovf = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int bw(input logic [1:0] m);
      if (m == 2'd1) return 2;
      if (m == 2'd2) return 4;
      return 1;
   endfunction

   function automatic int beat_of(input logic [1:0] m, input logic [3:0] io);
      if (bw(m) == 4) return int'(io);
      if (bw(m) == 2) return int'(io[1:0]);
      return int'(io[1]);
   endfunction

   task automatic model_reset();
      exp_q.delete();
      beat_q.delete();
      m_cnt = 0;
      m_ovf = 0;
   endtask

   // Applies the current inputs as they will be seen at the coming clock edge.
   task automatic model_edge();
      int w, n;
      bit pop, push;
      longint unsigned word;
      if (clr_i) begin
         model_reset();
         return;
      end
      w    = bw(mode_i);
      pop  = (exp_q.size() > 0) && rx_if.rx_ready_i;
      push = 0;
      word = 0;
      if (!en_i) begin
         beat_q.delete();
         m_cnt = 0;
      end else if (smp_i) begin
         beat_q.push_back(beat_of(mode_i, spi_io_in_i));
         m_cnt += w;
         if (m_cnt >= 8 * (int'(size_i) + 1)) begin
            n = beat_q.size();
            for (int k = 0; k < n; k++) begin
               if (lsb_i) word += longint'(beat_q[k]) * (64'd1 << (w * k));
               else       word += longint'(beat_q[k]) * (64'd1 << (w * (n - 1 - k)));
            end
            push = 1;
            beat_q.delete();
            m_cnt = 0;
         end
      end
      if (pop) void'(exp_q.pop_front());
      if (push) begin
         if (exp_q.size() < DEPTH) exp_q.push_back(word[31:0]);
         else m_ovf = 1;
      end
   endtask

   task automatic check_outputs();
      chk("valid", {31'd0, rx_if.rx_valid_o}, {31'd0, exp_q.size() > 0});
      chk("ovf", {31'd0, ovf_o}, {31'd0, m_ovf});
      chk("bit_cnt", {26'd0, bit_cnt_o}, 32'(m_cnt));
      if (exp_q.size() > 0) chk("data", rx_if.rx_data_o, exp_q[0]);
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk_i);
      #1;
      check_outputs();
   endtask

   task automatic send_beat(input int b, input bit rdy_now);
      logic [3:0] io;
      logic [3:0] bv;
      io = 4'($urandom_range(0, 15));
      bv = 4'(b);
      if (bw(mode_i) == 4) io = bv;
      else if (bw(mode_i) == 2) io[1:0] = bv[1:0];
      else io[1] = bv[0];
      spi_io_in_i = io;
      smp_i = 1'b1;
      rx_if.rx_ready_i = rdy_now;
      tick();
      smp_i = 1'b0;
      rx_if.rx_ready_i = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] v, input bit rdy_last);
      for (int i = 7; i >= 0; i--) send_beat(int'(v[i]), (i == 0) ? rdy_last : 1'b0);
   endtask

   task automatic set_cfg(input logic [1:0] m, input logic [1:0] s, input logic l);
      mode_i = m;
      size_i = s;
      lsb_i  = l;
   endtask

   task automatic drain();
      rx_if.rx_ready_i = 1'b1;
      repeat (3) tick();
      rx_if.rx_ready_i = 1'b0;
   endtask

   initial begin
      int dual_b[8];
      rst_n_i = 1'b0; clr_i = 1'b0; en_i = 1'b0; smp_i = 1'b0;
      mode_i = 2'd0; size_i = 2'd0; lsb_i = 1'b0; spi_io_in_i = 4'd0;
      rx_if.rx_ready_i = 1'b0;
      model_reset();
      repeat (3) @(posedge clk_i);
      #1;
      chk("rst_data", rx_if.rx_data_o, 32'd0);
      rst_n_i = 1'b1;
      tick();

      // Std 8-bit MSB-first
      set_cfg(2'd0, 2'd0, 1'b0);
      en_i = 1'b1;
      tick();
      send_byte(8'hA5, 1'b0);
      chk("std8_data", rx_if.rx_data_o, 32'h0000_00A5);
      chk("std8_cnt", {26'd0, bit_cnt_o}, 32'd0);
      drain();

      // Quad 32-bit LSB-first
      set_cfg(2'd2, 2'd3, 1'b1);
      for (int i = 0; i < 8; i++) send_beat(8 - i, 1'b0);
      chk("quad32_data", rx_if.rx_data_o, 32'h1234_5678);
      drain();

      // Dual 16-bit MSB-first, held for 10 cycles without ready
      set_cfg(2'd1, 2'd1, 1'b0);
      dual_b = '{3, 0, 2, 1, 1, 3, 0, 2};
      for (int i = 0; i < 8; i++) send_beat(dual_b[i], 1'b0);
      for (int i = 0; i < 10; i++) begin
         chk("dual16_hold", rx_if.rx_data_o, 32'h0000_C972);
         tick();
      end
      drain();

      // Overflow: one more word than the buffer holds, then pop in order
      set_cfg(2'd0, 2'd0, 1'b0);
      for (int k = 0; k <= DEPTH; k++) send_byte(8'(8'h11 * (k + 1)), 1'b0);
      tick();
      chk("ovf_set", {31'd0, ovf_o}, 32'd1);
      rx_if.rx_ready_i = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
         chk("ovf_order", rx_if.rx_data_o, 32'(8'h11 * (k + 1)));
         tick();
      end
      chk("ovf_empty", {31'd0, rx_if.rx_valid_o}, 32'd0);
      rx_if.rx_ready_i = 1'b0;
      clr_i = 1'b1;
      tick();
      clr_i = 1'b0;
      chk("ovf_clr", {31'd0, ovf_o}, 32'd0);

      // Full buffer, completion coincides with ready
      for (int k = 0; k < DEPTH; k++) send_byte(8'(8'h40 + k), 1'b0);
      send_byte(8'h5A, 1'b1);
      chk("pushpop_ovf", {31'd0, ovf_o}, 32'd0);
      chk("pushpop_vld", {31'd0, rx_if.rx_valid_o}, 32'd1);
      drain();

      // Abort after 5 bits, then a fresh 0xFF
      for (int i = 0; i < 5; i++) send_beat(0, 1'b0);
      en_i = 1'b0;
      tick();
      chk("abort_cnt", {26'd0, bit_cnt_o}, 32'd0);
      en_i = 1'b1;
      send_byte(8'hFF, 1'b0);
      chk("abort_data", rx_if.rx_data_o, 32'h0000_00FF);
      drain();

      // clr mid-word with overflow pending
      for (int k = 0; k <= DEPTH; k++) send_byte(8'h33, 1'b0);
      for (int i = 0; i < 3; i++) send_beat(1, 1'b0);
      chk("clr_pre_cnt", {26'd0, bit_cnt_o}, 32'd3);
      clr_i = 1'b1;
      tick();
      clr_i = 1'b0;
      chk("clr_cnt", {26'd0, bit_cnt_o}, 32'd0);
      chk("clr_ovf", {31'd0, ovf_o}, 32'd0);
      chk("clr_vld", {31'd0, rx_if.rx_valid_o}, 32'd0);

      // Asynchronous reset mid-word with a word buffered
      send_byte(8'h77, 1'b0);
      for (int i = 0; i < 3; i++) send_beat(1, 1'b0);
      rst_n_i = 1'b0;
      #2;
      chk("arst_vld", {31'd0, rx_if.rx_valid_o}, 32'd0);
      chk("arst_cnt", {26'd0, bit_cnt_o}, 32'd0);
      chk("arst_data", rx_if.rx_data_o, 32'd0);
      model_reset();
      @(posedge clk_i);
      #1;
      rst_n_i = 1'b1;
      tick();
      send_byte(8'h3C, 1'b0);
      chk("arst_next", rx_if.rx_data_o, 32'h0000_003C);
      drain();

      // Randomized traffic; config only changes while en_i is low
      en_i = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         clr_i = ($urandom_range(0, 299) == 0);
         if (!en_i) begin
            set_cfg(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            en_i = ($urandom_range(0, 3) != 0);
         end else if ($urandom_range(0, 79) == 0) begin
            en_i = 1'b0;
         end
         smp_i = 1'($urandom_range(0, 1));
         spi_io_in_i = 4'($urandom_range(0, 15));
         rx_if.rx_ready_i = ($urandom_range(0, 2) != 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
